alu_seq: RTL

- Parametrised, registered successor of the combinational 32-bit ALU, for the EX stage of the MIPS pipeline.
- Supports AND/OR/ADD/SUB/SLT with one-cycle registered latency.
- Adds a multi-cycle signed multiply (MULT) that produces a HI/LO pair.
- Uses a valid/ready handshake on both sides so the pipeline can stall on multiply.
- SLT returns the correct signed result even when the subtraction overflows; no X results.

---
 rtl/alu_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered EX-stage ALU: AND/OR/ADD/SUB/SLT in one cycle, plus a multi-cycle signed
// shift-add multiply that returns a {hi, result} product pair.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic [1:0]       dbg_state
);

    // Handshake: a request transfers on a rising edge with in_valid && in_ready, and the
    // requester holds op/operands until then; a result stays on the outputs with out_valid
    // high until a rising edge with out_ready high.

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;

    localparam int MSB = WIDTH - 1;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
    localparam logic [WIDTH:0]     ONE_W1 = (WIDTH + 1)'(1);
    localparam logic [2*WIDTH-1:0] ONE_P  = (2 * WIDTH)'(1);
    localparam logic [CNT_W-1:0]   LAST   = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH:0]     mcand_q, mcand_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               ill_q, ill_d;

    logic               accept;
    logic [WIDTH-1:0]   sum, diff, alu_res;
    logic               ovf_add, ovf_sub, alu_ovf, alu_ill;
    logic [WIDTH:0]     a_ext, a_mag, partial;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH:0]   acc_step;
    logic [2*WIDTH-1:0] prod_mag, prod;

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign out_valid = (state_q == S_DONE);
    assign accept    = in_valid && in_ready;
    assign result    = result_q;
    assign hi        = hi_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;
    assign dbg_state = state_q;

    always_comb begin
        sum     = a_in + b_in;
        diff    = a_in + ~b_in + ONE_W;
        ovf_add = (a_in[MSB] == b_in[MSB]) && (sum[MSB] != a_in[MSB]);
        ovf_sub = (a_in[MSB] != b_in[MSB]) && (diff[MSB] != a_in[MSB]);
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_AND: alu_res = a_in & b_in;
            OP_OR:  alu_res = a_in | b_in;
            OP_ADD: begin alu_res = sum;  alu_ovf = ovf_add; end
            OP_SUB: begin alu_res = diff; alu_ovf = ovf_sub; end
            // Correcting the sign bit with the overflow flag keeps SLT right at the extremes.
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, diff[MSB] ^ ovf_sub};
            OP_MUL: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // Magnitudes: A is widened so that |most-negative| is representable; B's magnitude
    // fits as an unsigned WIDTH-bit value even for the most-negative code.
    always_comb begin
        a_ext    = {a_in[MSB], a_in};
        a_mag    = a_in[MSB] ? (~a_ext + ONE_W1) : a_ext;
        b_mag    = b_in[MSB] ? (~b_in + ONE_W) : b_in;
        partial  = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? mcand_q : '0);
        acc_step = {1'b0, partial, acc_q[WIDTH-1:1]};
        prod_mag = acc_step[2*WIDTH-1:0];
        prod     = neg_q ? (~prod_mag + ONE_P) : prod_mag;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        case (state_q)
            S_IDLE: ;
            S_MUL: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d  = S_DONE;
                    result_d = prod[WIDTH-1:0];
                    hi_d     = prod[2*WIDTH-1:WIDTH];
                    zero_d   = (prod[WIDTH-1:0] == '0);
                    ovf_d    = 1'b0;
                    ill_d    = 1'b0;
                end
            end
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A new accept overrides the DONE->IDLE release so throughput stays at one per cycle.
        if (accept) begin
            if (op == OP_MUL) begin
                state_d = S_MUL;
                cnt_d   = '0;
                acc_d   = {{(WIDTH+1){1'b0}}, b_mag};
                mcand_d = a_mag;
                neg_d   = a_in[MSB] ^ b_in[MSB];
            end else begin
                state_d  = S_DONE;
                result_d = alu_res;
                hi_d     = '0;
                zero_d   = (alu_res == '0);
                ovf_d    = alu_ovf;
                ill_d    = alu_ill;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
        end
    end

endmodule
